// File: rtl/scd_ctrl_if.sv
// Signal bundle between the SIGNAL-field sequencer and its neighbours.
// master: sequencer side; slave: demodulator/SCD/config side.
interface scd_ctrl_if;
   logic        start;
   logic        in_di;
   logic        in_di_vld;
   logic        scd_di;
   logic        scd_di_vld;
   logic        scd_rst;
   logic        dec_bit;
   logic        dec_vld;
   logic        busy;
   logic        sig_vld;
   logic        sig_ok;
   logic [3:0]  sig_rate;
   logic [11:0] sig_len;
   logic [2:0]  err_code;

   modport master (
      input  start, in_di, in_di_vld, dec_bit, dec_vld,
      output scd_di, scd_di_vld, scd_rst, busy,
      output sig_vld, sig_ok, sig_rate, sig_len, err_code
   );

   modport slave (
      output start, in_di, in_di_vld, dec_bit, dec_vld,
      input  scd_di, scd_di_vld, scd_rst, busy,
      input  sig_vld, sig_ok, sig_rate, sig_len, err_code
   );
endinterface

// File: rtl/scd_ctrl.sv
// scd_ctrl: gates N_CODED coded bits into the SCD, collects N_SIG decoded
// SIGNAL bits, checks parity/rate/tail/length and publishes RATE/LENGTH.
// Ports: clk, rst (async, active high), bus (scd_ctrl_if.master):
//   start, in_di/in_di_vld in; scd_di/scd_di_vld/scd_rst out to SCD;
//   dec_bit/dec_vld in; busy, sig_vld, sig_ok, sig_rate, sig_len,
//   err_code out (result fields held between strobes).
// Option: define SCD_RSV_CHK_EN to flag reserved bit sig[4] as err 6.
module scd_ctrl #(
   parameter int N_CODED = 48,
   parameter int N_SIG   = 24,
   parameter int TIMEOUT = 512
) (
   input  logic       clk,
   input  logic       rst,
   scd_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      IDLE, FEED, WAIT, CHECK, DONE
   } state_t;

   localparam int IW = $clog2(N_CODED + 1);
   localparam int DW = $clog2(N_SIG + 1);
   localparam int TW = 10;

   state_t            state, state_nx;
   logic [IW-1:0]     in_cnt;
   logic [DW-1:0]     dec_cnt;
   logic [TW-1:0]     to_cnt;
   logic [N_SIG-1:0]  sig;
   logic              rec_pulse;
   logic              in_last;
   logic              dec_take;
   logic              dec_full;
   logic              dec_last;
   logic              to_hit;
   logic [2:0]        err;

   assign in_last  = bus.in_di_vld &&
                     (in_cnt == IW'(N_CODED - 1));
   assign dec_full = (dec_cnt == DW'(N_SIG));
   // SCD may emit early, so decoded bits are taken in FEED as well.
   assign dec_take = bus.dec_vld && !dec_full &&
                     (state == FEED || state == WAIT);
   assign dec_last = dec_take &&
                     (dec_cnt == DW'(N_SIG - 1));
   assign to_hit   = !bus.dec_vld &&
                     (to_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (bus.start) state_nx = FEED;
         FEED:  if (in_last) state_nx = WAIT;
         WAIT: begin
            if (dec_last || dec_full) state_nx = CHECK;
            else if (to_hit)          state_nx = DONE;
         end
         CHECK: state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.busy       = (state != IDLE);
      bus.scd_di_vld = (state == FEED) && bus.in_di_vld;
      bus.scd_di     = (state == FEED) && bus.in_di;
      bus.sig_vld    = (state == DONE);
   end

   // SCD reset must follow rst with no clock, hence combinational.
   assign bus.scd_rst = rst | rec_pulse;

   // Field checks in priority order; first failing one wins.
   always_comb begin
      err = 3'd0;
      if (^sig[17:0])             err = 3'd1;
      else if (!sig[3])           err = 3'd2;
      else if (|sig[23:18])       err = 3'd3;
      else if (sig[16:5] == '0)   err = 3'd4;
`ifdef SCD_RSV_CHK_EN
      else if (sig[4])            err = 3'd6;
`else
      else                        err = 3'd0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_cnt       <= '0;
         dec_cnt      <= '0;
         to_cnt       <= '0;
         sig          <= '0;
         rec_pulse    <= 1'b0;
         bus.sig_ok   <= 1'b0;
         bus.sig_rate <= '0;
         bus.sig_len  <= '0;
         bus.err_code <= '0;
      end else begin
         rec_pulse <= 1'b0;
         if (state == IDLE && bus.start) begin
            in_cnt  <= '0;
            dec_cnt <= '0;
            to_cnt  <= '0;
            sig     <= '0;
         end
         if (state == FEED && bus.in_di_vld)
            in_cnt <= in_cnt + IW'(1);
         if (dec_take) begin
            sig[dec_cnt] <= bus.dec_bit;
            dec_cnt      <= dec_cnt + DW'(1);
         end
         if (state == WAIT)
            to_cnt <= bus.dec_vld ? '0 : to_cnt + TW'(1);
         // Timeout: keep old RATE/LENGTH, kick the SCD for one cycle.
         if (state == WAIT && state_nx == DONE) begin
            rec_pulse    <= 1'b1;
            bus.err_code <= 3'd5;
            bus.sig_ok   <= 1'b0;
         end
         if (state == CHECK) begin
            bus.sig_rate <= sig[3:0];
            bus.sig_len  <= sig[16:5];
            bus.err_code <= err;
            bus.sig_ok   <= (err == 3'd0);
         end
      end
   end
endmodule

// File: tb/tb_scd_ctrl.sv
// tb_scd_ctrl: directed bench for scd_ctrl with a transaction-level
// reference model checked every cycle plus literal pin-down checks.
module tb_scd_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;

   scd_ctrl_if bus ();

   scd_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, got, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 gating coded bits,
   // 2 collecting decoded bits, 3 judging, 4 reporting.
   int          ph = 0;
   int          fed = 0;
   int          quiet = 0;
   bit          q[$];
   bit          m_to = 0;
   logic        m_ok = 0;
   logic [3:0]  m_rate = 0;
   logic [11:0] m_len = 0;
   logic [2:0]  m_err = 0;
   int          n_fwd = 0;
   int          n_vld = 0;
   int          n_rec = 0;

   function automatic int field(input bit b[$], input int lo,
                                input int w);
      int v = 0;
      for (int i = 0; i < w; i++) v += int'(b[lo + i]) << i;
      return v;
   endfunction

   function automatic logic [2:0] judge(input bit b[$]);
      int ones = 0;
      for (int i = 0; i < 18; i++) ones += int'(b[i]);
      if (ones % 2 == 1) return 3'd1;
      if (b[3] == 1'b0) return 3'd2;
      if (field(b, 18, 6) != 0) return 3'd3;
      if (field(b, 5, 12) == 0) return 3'd4;
`ifdef SCD_RSV_CHK_EN
      if (b[4]) return 3'd6;
`endif
      return 3'd0;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_busy", bus.busy, 0);
         chk("rst_scd_rst", bus.scd_rst, 1);
         chk("rst_scd_di_vld", bus.scd_di_vld, 0);
         chk("rst_sig_vld", bus.sig_vld, 0);
         chk("rst_sig_ok", bus.sig_ok, 0);
         chk("rst_sig_rate", bus.sig_rate, 0);
         chk("rst_sig_len", bus.sig_len, 0);
         chk("rst_err_code", bus.err_code, 0);
         ph = 0;
         q.delete();
         m_to = 0;
         m_ok = 0;
         m_rate = 0;
         m_len = 0;
         m_err = 0;
      end else begin
         chk("busy", bus.busy, ph != 0);
         chk("scd_di_vld", bus.scd_di_vld,
             ph == 1 && bus.in_di_vld);
         chk("scd_di", bus.scd_di, ph == 1 && bus.in_di);
         chk("sig_vld", bus.sig_vld, ph == 4);
         chk("scd_rst", bus.scd_rst, ph == 4 && m_to);
         chk("sig_ok", bus.sig_ok, m_ok);
         chk("sig_rate", bus.sig_rate, m_rate);
         chk("sig_len", bus.sig_len, m_len);
         chk("err_code", bus.err_code, m_err);
         if (bus.scd_di_vld) n_fwd++;
         if (bus.sig_vld) n_vld++;
         if (bus.scd_rst) n_rec++;
         case (ph)
            0: if (bus.start) begin
               ph = 1;
               fed = 0;
               quiet = 0;
               q.delete();
            end
            1: begin
               if (bus.dec_vld && q.size() < 24)
                  q.push_back(bus.dec_bit);
               if (bus.in_di_vld) begin
                  fed++;
                  if (fed == 48) begin
                     ph = 2;
                     quiet = 0;
                  end
               end
            end
            2: begin
               if (bus.dec_vld) begin
                  quiet = 0;
                  if (q.size() < 24) q.push_back(bus.dec_bit);
               end else begin
                  quiet++;
               end
               if (q.size() == 24) begin
                  ph = 3;
               end else if (quiet == 512) begin
                  ph = 4;
                  m_to = 1;
                  m_err = 3'd5;
                  m_ok = 0;
               end
            end
            3: begin
               m_rate = 4'(field(q, 0, 4));
               m_len = 12'(field(q, 5, 12));
               m_err = judge(q);
               m_ok = (m_err == 3'd0);
               m_to = 0;
               ph = 4;
            end
            default: ph = 0;
         endcase
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start(input bit with_bit);
      bus.start = 1'b1;
      bus.in_di_vld = with_bit;
      bus.in_di = 1'b1;
      cyc();
      bus.start = 1'b0;
      bus.in_di_vld = 1'b0;
      bus.in_di = 1'b0;
   endtask

   task automatic feed(input int n);
      for (int i = 0; i < n; i++) begin
         bus.in_di_vld = 1'b1;
         bus.in_di = 1'($urandom);
         cyc();
      end
      bus.in_di_vld = 1'b0;
      bus.in_di = 1'b0;
   endtask

   task automatic send(input logic [23:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         bus.dec_vld = 1'b1;
         bus.dec_bit = v[i];
         cyc();
      end
      bus.dec_vld = 1'b0;
      bus.dec_bit = 1'b0;
   endtask

   function automatic logic [23:0] mk(input logic [3:0] rate,
                                      input bit rsv,
                                      input logic [11:0] len,
                                      input bit par,
                                      input logic [5:0] tail);
      return {tail, par, len, rsv, rate};
   endfunction

   task automatic run_full(input string nm, input logic [23:0] v,
                           input logic [3:0] e_rate,
                           input logic [11:0] e_len,
                           input logic [2:0] e_err,
                           input int nfeed, input bit poke);
      int f0;
      f0 = n_fwd;
      pulse_start(1'b1);
      feed(nfeed);
      if (poke) begin
         bus.start = 1'b1;
         cyc();
         bus.start = 1'b0;
         chk({nm, "_poke_busy"}, bus.busy, 1);
      end
      send(v, 24);
      chk({nm, "_lat1"}, bus.sig_vld, 0);
      cyc();
      chk({nm, "_lat2"}, bus.sig_vld, 1);
      chk({nm, "_err"}, bus.err_code, e_err);
      chk({nm, "_ok"}, bus.sig_ok, e_err == 3'd0);
      chk({nm, "_rate"}, bus.sig_rate, e_rate);
      chk({nm, "_len"}, bus.sig_len, e_len);
      cyc();
      chk({nm, "_idle"}, bus.busy, 0);
      chk({nm, "_fwd"}, n_fwd - f0, 48);
   endtask

   logic [23:0] nom;
   int          n;
   int          r0;
   int          v0;

   initial begin
      bus.start = 1'b0;
      bus.in_di = 1'b0;
      bus.in_di_vld = 1'b0;
      bus.dec_bit = 1'b0;
      bus.dec_vld = 1'b0;
      #1 rst = 1'b1;
      cyc(3);
      rst = 1'b0;
      cyc(2);
      chk("post_rst_busy", bus.busy, 0);
      chk("post_rst_scd_rst", bus.scd_rst, 0);

      bus.dec_vld = 1'b1;
      bus.dec_bit = 1'b1;
      cyc(3);
      bus.dec_vld = 1'b0;
      bus.dec_bit = 1'b0;
      chk("idle_dec_busy", bus.busy, 0);

      nom = mk(4'hD, 1'b0, 12'h064, 1'b0, 6'd0);
      run_full("nom", nom, 4'hD, 12'h064, 3'd0, 48, 1'b0);
      run_full("par", mk(4'hD, 1'b0, 12'h064, 1'b1, 6'd0),
               4'hD, 12'h064, 3'd1, 48, 1'b0);
      run_full("prio", mk(4'b0101, 1'b0, 12'h000, 1'b0, 6'b000001),
               4'b0101, 12'h000, 3'd2, 48, 1'b0);
      run_full("tail", mk(4'hD, 1'b0, 12'h064, 1'b0, 6'b100000),
               4'hD, 12'h064, 3'd3, 48, 1'b0);
      run_full("len0", mk(4'hD, 1'b0, 12'h000, 1'b1, 6'd0),
               4'hD, 12'h000, 3'd4, 48, 1'b0);
`ifdef SCD_RSV_CHK_EN
      run_full("rsv", mk(4'hD, 1'b1, 12'h064, 1'b1, 6'd0),
               4'hD, 12'h064, 3'd6, 48, 1'b0);
`else
      run_full("rsv", mk(4'hD, 1'b1, 12'h064, 1'b1, 6'd0),
               4'hD, 12'h064, 3'd0, 48, 1'b0);
`endif
      run_full("gate", nom, 4'hD, 12'h064, 3'd0, 60, 1'b1);

      pulse_start(1'b0);
      feed(48);
      send(nom, 10);
      r0 = n_rec;
      n = 0;
      while (!bus.sig_vld && n < 600) begin
         cyc();
         n++;
      end
      chk("to_wait", n, 512);
      chk("to_err", bus.err_code, 5);
      chk("to_ok", bus.sig_ok, 0);
      chk("to_rate_kept", bus.sig_rate, 4'hD);
      chk("to_len_kept", bus.sig_len, 12'h064);
      cyc();
      chk("to_rec_pulses", n_rec - r0, 1);
      chk("to_idle", bus.busy, 0);

      pulse_start(1'b0);
      feed(48);
      send(nom, 12);
      v0 = n_vld;
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_scd_rst", bus.scd_rst, 1);
      chk("mid_rst_err", bus.err_code, 0);
      cyc(2);
      rst = 1'b0;
      cyc(30);
      chk("mid_rst_no_vld", n_vld - v0, 0);
      chk("mid_rst_idle", bus.busy, 0);
      run_full("after_rst", nom, 4'hD, 12'h064, 3'd0, 48, 1'b0);

      cyc(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/scd_ctrl.md
Name: scd_ctrl

Overview:
Sequencer for the Signal Channel Decoder. On a start pulse it gates exactly N_CODED soft-decision coded bits from the demodulator into the decoder, then collects the 24 decoded SIGNAL bits. It checks parity, rate, tail and length, publishes RATE/LENGTH to the data-path configuration, and recovers the decoder on timeout.

Parameters:
N_CODED, 48, coded bits gated into SCD per SIGNAL field
N_SIG, 24, decoded bits collected
TIMEOUT, 512, max cycles in WAIT before abort (counter width 10)

Ports:
clk  in  1  working clock
rst  in  1  asynchronous reset, active high
start  in  1  one-cycle pulse: SIGNAL symbol begins
in_di  in  1  demodulated coded bit
in_di_vld  in  1  in_di valid
scd_di  out  1  coded bit to SCD
scd_di_vld  out  1  valid to SCD
scd_rst  out  1  reset to SCD (rst OR recovery pulse)
dec_bit  in  1  decoded bit from SCD
dec_vld  in  1  dec_bit valid
busy  out  1  high in any state but IDLE
sig_vld  out  1  one-cycle result strobe
sig_ok  out  1  result passed all checks (held until next sig_vld)
sig_rate  out  4  RATE field (held)
sig_len  out  12  LENGTH field (held)
err_code  out  3  0 ok, 1 parity, 2 rate, 3 tail, 4 length zero, 5 timeout, 6 reserved bit (held)

Behaviour:
- Reset: FSM=IDLE; counters 0; all registered outputs 0. scd_rst = rst OR rec_pulse, asynchronously asserted.
- FSM states: IDLE, FEED, WAIT, CHECK, DONE.
- IDLE: start -> FEED; clear in_cnt, dec_cnt, to_cnt and the shift register. in_di_vld in IDLE is dropped: scd_di_vld=0.
- FEED: scd_di=in_di, scd_di_vld=in_di_vld, combinational pass-through with zero latency. Each valid bit increments in_cnt. The cycle carrying valid bit number N_CODED moves to WAIT. Valid bits after that are dropped.
- WAIT: each dec_vld stores dec_bit into sig[dec_cnt]. First bit goes to sig[0] (R1). dec_cnt increments. The 24th bit moves to CHECK. to_cnt increments every WAIT cycle and clears on each dec_vld. to_cnt==TIMEOUT-1 with no dec_vld moves to DONE with err 5 and asserts rec_pulse for 1 cycle.
- dec_vld in FEED is accepted and counted, because SCD may emit early. dec_vld in IDLE, CHECK or DONE is ignored. Decoded bits beyond 24 are ignored.
- Field map: rate=sig[3:0], rsv=sig[4], len=sig[16:5] (sig[5]=LSB), par=sig[17], tail=sig[23:18].
- CHECK (1 cycle): error priority is parity, then rate, then tail, then length, then reserved.
  - Parity: XOR of sig[17:0] must be 0.
  - Rate: rate[3] must be 1.
  - Tail: tail must be 0.
  - Length: len must not be 0.
  - Latch sig_rate, sig_len, err_code; sig_ok=(err==0). Go to DONE.
- DONE (1 cycle): sig_vld=1, then IDLE.
- Timing: sig_vld rises 2 cycles after the cycle of the 24th dec_vld. On timeout, sig_rate and sig_len keep their previous values.
- start while busy: ignored.
- start and the first in_di_vld in the same cycle: the bit is dropped, because the gate opens the next cycle.
- Async rst mid-operation: immediate return to IDLE. Outputs go to reset values and SCD is held in reset.

Optional Feature:
SCD_RSV_CHK_EN. When defined, a reserved bit sig[4]=1 yields err_code 6, which has the lowest priority. When undefined, sig[4] is ignored and code 6 is never produced.

Test Plan:
- Nominal: start, 48 coded bits, then SCD returns rate=1101, len=100 (0x064), rsv=0, par=0, tail=0 -> sig_vld once, sig_ok=1, sig_rate=4'hD, sig_len=12'h064, err_code=0, 2 cycles after the 24th bit; exactly 48 scd_di_vld pulses.
- Parity error: same fields with par=1 -> sig_ok=0, err_code=1, fields still latched.
- Priority: rate=0101 plus len=0 plus tail=6'b000001 -> err_code=2. Tail-only fault -> 3. Len=0 only -> 4.
- Timeout: feed 48 bits, return 10 decoded bits, then silence -> after 512 idle cycles sig_vld with err_code=5; scd_rst high exactly 1 cycle; previous sig_rate/sig_len unchanged.
- Gating/ignore: 60 in_di_vld after start -> only 48 forwarded. A start pulse during WAIT has no effect. dec_vld while IDLE -> no state change.
- Reset mid-WAIT: assert rst after 12 decoded bits -> busy=0, sig_vld never fires. The next start runs nominal to completion. With SCD_RSV_CHK_EN defined, rsv=1 and otherwise valid fields -> err_code=6.
